// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: drives the PC register, issues single-outstanding imem
// reads, and buffers responses in an in-order queue feeding ID. Handles EX redirects.
module inst_fetch_unit #(
  parameter int DATA_W  = 32,
  parameter int QDEPTH  = 2,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  output logic              pc_stall,
  output logic [DATA_W-1:0] new_pc,
  output logic              imem_req_valid,
  output logic [DATA_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_inst,
  output logic [DATA_W-1:0] id_pc,
  input  logic              id_ready
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] align_pc(input logic [DATA_W-1:0] pc);
    return pc & ~DATA_W'(3);
  endfunction

  function automatic logic [DATA_W-1:0] seq_pc(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(PC_STEP);
  endfunction

  state_t            state_q, state_d;
  logic              outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [DATA_W-1:0] pend_pc_q;
  logic [DATA_W-1:0] q_inst_q [QDEPTH];
  logic [DATA_W-1:0] q_pc_q   [QDEPTH];

  logic req_fire;
  logic push;
  logic pop;

  // Slots are reserved at issue time: queued entries plus the in-flight one.
  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && state_q == ST_ISSUE && !redirect_valid &&
        ((count_q + CNT_W'(outstanding_q)) < DEPTH_C)) begin
      imem_req_valid = 1'b1;
    end
  end

  assign imem_req_addr = pc_in;
  assign req_fire      = imem_req_valid & imem_req_ready;
  assign push          = !rst && (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;
  assign id_valid      = !rst && (count_q != '0);
  assign pop           = id_valid && id_ready && !redirect_valid;
  assign id_inst       = q_inst_q[head_q];
  assign id_pc         = q_pc_q[head_q];

  always_comb begin
    pc_stall = 1'b1;
    new_pc   = pc_in;
    if (rst) begin
      pc_stall = 1'b1;
      new_pc   = '0;
    end else if (redirect_valid) begin
      pc_stall = 1'b0;
      new_pc   = align_pc(redirect_pc);
    end else if (req_fire) begin
      pc_stall = 1'b0;
      new_pc   = seq_pc(pc_in);
    end
  end

  // A redirect while a request is in flight turns its response stale (DRAIN).
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    case (state_q)
      ST_ISSUE: begin
        if (req_fire) begin
          state_d       = ST_WAIT;
          outstanding_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          state_d       = ST_ISSUE;
          outstanding_d = 1'b0;
        end else if (redirect_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_resp_valid) begin
          state_d       = ST_ISSUE;
          outstanding_d = 1'b0;
        end
      end
      default: begin
        state_d       = ST_ISSUE;
        outstanding_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (redirect_valid) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ISSUE;
      outstanding_q <= 1'b0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pend_pc_q <= pc_in;
    if (push) begin
      q_pc_q[tail_q]   <= pend_pc_q;
      q_inst_q[tail_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: acts as PC register and instruction memory,
// and checks every cycle against a transaction-level queue model.
module tb_inst_fetch_unit;
  localparam int W    = 32;
  localparam int QD   = 2;
  localparam int NCYC = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc_in;
  logic         pc_stall;
  logic [W-1:0] new_pc;
  logic         imem_req_valid;
  logic [W-1:0] imem_req_addr;
  logic         imem_req_ready;
  logic         imem_resp_valid;
  logic [W-1:0] imem_resp_data;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         id_valid;
  logic [W-1:0] id_inst;
  logic [W-1:0] id_pc;
  logic         id_ready;

  always #5 clk = ~clk;

  inst_fetch_unit #(.DATA_W(W), .QDEPTH(QD), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_stall(pc_stall), .new_pc(new_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_ready(id_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: fetched-but-unconsumed instructions in program order.
  logic [W-1:0] mq_pc[$];
  logic [W-1:0] mq_inst[$];
  bit           busy, stale;
  logic [W-1:0] pend;

  // Environment state.
  int           resp_due;
  logic [W-1:0] resp_word;
  logic [W-1:0] pc_next;
  bit           new_rst;
  int           phase;

  bit           exp_req, hs, exp_idv, exp_stall;
  logic [W-1:0] exp_new;

  initial begin
    rst = 1'b1; pc_in = '0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    busy = 0; stale = 0; pend = '0; resp_due = 0; resp_word = '0; pc_next = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      exp_idv   = !rst && (mq_pc.size() != 0);
      exp_req   = !rst && !busy && (mq_pc.size() < QD) && !redirect_valid;
      hs        = exp_req && imem_req_ready;
      exp_stall = 1'b1;
      exp_new   = '0;
      if (rst) begin
        exp_stall = 1'b1;
        exp_new   = '0;
      end else if (redirect_valid) begin
        exp_stall = 1'b0;
        exp_new   = redirect_pc & 32'hFFFF_FFFC;
      end else if (hs) begin
        exp_stall = 1'b0;
        exp_new   = pc_in + 32'd4;
      end

      chk("id_valid", 32'(id_valid), 32'(exp_idv));
      if (exp_idv) begin
        chk("id_pc", id_pc, mq_pc[0]);
        chk("id_inst", id_inst, mq_inst[0]);
      end
      chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) chk("imem_req_addr", imem_req_addr, pc_in);
      chk("pc_stall", 32'(pc_stall), 32'(exp_stall));
      if (!exp_stall || rst) chk("new_pc", new_pc, exp_new);

      if (rst) begin
        mq_pc.delete(); mq_inst.delete();
        busy = 0; stale = 0;
      end else if (redirect_valid) begin
        mq_pc.delete(); mq_inst.delete();
        if (busy) begin
          if (imem_resp_valid) begin busy = 0; stale = 0; end
          else stale = 1;
        end
      end else begin
        if (exp_idv && id_ready) begin
          void'(mq_pc.pop_front());
          void'(mq_inst.pop_front());
        end
        if (busy && imem_resp_valid) begin
          if (!stale) begin
            mq_pc.push_back(pend);
            mq_inst.push_back(imem_resp_data);
          end
          busy = 0; stale = 0;
        end
        if (hs) begin busy = 1; pend = pc_in; end
      end

      if (rst)             pc_next = '0;
      else if (!exp_stall) pc_next = exp_new;
      else                 pc_next = pc_in;
      if (hs) begin
        resp_due  = (phase == 0) ? 1 : int'($urandom_range(1, 3));
        resp_word = $urandom;
      end

      @(posedge clk);
      #1;
      phase   = (cyc < 300) ? 0 : (cyc < 600) ? 1 : 2;
      new_rst = (cyc < 2) || (phase == 2 && $urandom_range(0, 99) == 0);
      pc_in   = pc_next;

      imem_resp_valid = 1'b0;
      if (new_rst) begin
        resp_due = 0;
      end else if (rst && cyc >= 2 && $urandom_range(0, 1) == 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = $urandom;
      end else if (resp_due > 0) begin
        resp_due--;
        if (resp_due == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = resp_word;
        end
      end
      rst = new_rst;

      case (phase)
        0: begin
          imem_req_ready = 1'b1;
          id_ready       = 1'b1;
          redirect_valid = 1'b0;
        end
        1: begin
          imem_req_ready = ($urandom_range(0, 1) == 1);
          id_ready       = ($urandom_range(0, 9) == 0);
          redirect_valid = 1'b0;
        end
        default: begin
          imem_req_ready = ($urandom_range(0, 3) != 0);
          id_ready       = ($urandom_range(0, 2) != 0);
          redirect_valid = ($urandom_range(0, 7) == 0);
        end
      endcase
      if ($urandom_range(0, 3) == 0) redirect_pc = {28'hFFF_FFFF, 4'($urandom_range(0, 15))};
      else                           redirect_pc = $urandom;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
